riscv_dift_tag_ex_unit: RTL and testbench
=========================================

Name: riscv_dift_tag_ex_unit

Overview:
Parametrised DIFT execute-stage tag unit, successor to the 1-bit in-line EX tag logic. Handles TAG_WIDTH-bit tags with per-mode propagation policies and a check mask, both run-time programmable. Holds a registered PC tag, the EX/WB load-address tag and a handshaked exception request FSM with saturating violation counter. Instantiated in the EX stage beside the ALU, driven by the ID/EX tag operands, feeding RF/LSU tag ports and the controller.

Parameters:
TAG_WIDTH, 4, width of every tag
MODE_WIDTH, 2, width of mode_i; NUM_MODES = 2**MODE_WIDTH
CNT_WIDTH, 8, width of violation counter

Ports:
clk  in  1  clock
rst_n  in  1  async reset, active low
mode_i  in  MODE_WIDTH  propagation mode of current EX instruction
tag_a_i / tag_b_i / tag_c_i  in  TAG_WIDTH each  tags of operand a, b, c (c = jump target)
check_s1_i / check_s2_i / check_d_i  in  1 each  enable check on a, b, result
register_set_i  in  1  force destination tag to all-ones
rf_we_i / data_we_i / load_i  in  1 each  ALU RF write, store, load in EX
branch_taken_i  in  1  branch/jump taken
ex_valid_i / wb_ready_i  in  1 each  EX valid, WB ready
cfg_we_i  in  1  write policy and mask registers
cfg_policy_i  in  2*NUM_MODES  2-bit op per mode, mode m at [2m+1:2m]
cfg_mask_i  in  TAG_WIDTH  check mask
cfg_clear_i  in  1  clear pc tag, counter, overrun
rf_wdata_tag_o / data_wdata_tag_o  out  TAG_WIDTH  RF / store data tag
rf_we_tag_o / data_we_tag_o  out  1 each  tag write enables
pc_tag_o  out  TAG_WIDTH  registered PC tag
rs1_tag_wb_o  out  TAG_WIDTH  load-address tag in WB
exc_req_o  out  1  tag exception request
exc_cause_o  out  3  {d,s2,s1} failing checks, latched
exc_ack_i  in  1  controller acknowledge
exc_overrun_o  out  1  sticky: violation lost while request pending
exc_count_o  out  CNT_WIDTH  saturating violation count

Behaviour:
- Reset: policy regs = 01 (OR) all modes, mask = all-ones; pc_tag_o, rs1_tag_wb_o, exc_cause_o, exc_count_o = 0; exc_req_o, exc_overrun_o = 0; FSM IDLE.
- Policy op (comb) on a,b: 00 CLEAR -> 0, write-enable 0; 01 OR; 10 AND; 11 PASS_A. res = op result.
- rf_wdata_tag_o = register_set_i ? all-ones : res; rf_we_tag_o = register_set_i | (rf_we_i & op!=00). data_wdata_tag_o = res; data_we_tag_o = data_we_i & op!=00. Zero latency.
- cfg_we_i: policy/mask updated at edge; effective next cycle. cfg_we_i and cfg_clear_i together: both apply.
- Violation (comb) v = {check_d_i & |(res&mask), check_s2_i & |(tag_b_i&mask), check_s1_i & |(tag_a_i&mask)}; the result check is suppressed when load_i=1. Event = ex_valid_i & |v.
- PC tag: on ex_valid_i & branch_taken_i: pc_tag <= (tag_c_i!=0) ? tag_c_i : res. Not-taken holds value. cfg_clear_i zeroes it; clear wins over simultaneous update.
- rs1_tag_wb_o <= tag_a_i when ex_valid_i & load_i; else holds (wb_ready_i without ex_valid_i does not change it).
- FSM IDLE: event -> REQ, latch cause = v, exc_req_o=1 from next cycle. REQ: exc_req_o=1, cause stable; exc_ack_i -> IDLE (req low next cycle). Event in REQ (incl. the ack cycle) -> exc_overrun_o <= 1, cause unchanged, no new REQ. The ack cycle is not eligible for a new request; the next event after IDLE is.
- exc_ack_i in IDLE: ignored.
- Counter increments on every event, both states, saturates at all-ones. cfg_clear_i zeroes counter and overrun; clear wins over increment. FSM is not affected by clear.
- Async reset mid-REQ: all state to reset values immediately.

Test Plan:
- Reset, mode 0 (OR), a=4'h1, b=4'h2, rf_we_i=1 -> rf_wdata_tag_o=4'h3, rf_we_tag_o=1; set policy mode0=00 -> rf_we_tag_o=0 next cycle.
- mask=4'h8, check_s1_i=1, a=4'h8, ex_valid_i=1 one cycle -> exc_req_o=1 next cycle, cause=3'b001, count=1; ack -> req 0 next cycle.
- Hold REQ, inject second event -> overrun=1, cause stays 3'b001, count=2; cfg_clear_i -> count 0, overrun 0, req still 1.
- Branch taken, tag_c=0, OR of a=4'h4, b=0 -> pc_tag_o=4'h4; next branch tag_c=4'h2 -> 4'h2; not-taken -> holds.
- Load with a=4'hA, check_d_i=1, res masked nonzero -> no exception; rs1_tag_wb_o=4'hA next cycle.
- 300 events with CNT_WIDTH=8 -> exc_count_o saturates at 8'hFF; rst_n low mid-REQ -> all outputs zero asynchronously.

Source files
------------

// File: rtl/riscv_dift_tag_ex_unit.sv
// DIFT EX-stage tag unit: programmable per-mode tag propagation,
// masked tag checks, PC / load-address tags and tag exception FSM.
// Ports:
//   cfg_*                     policy, mask and clear controls
//   tag_*_i, check_*_i, ...   ID/EX tag operands and EX controls
//   rf_*/data_* tag outputs   RF / LSU tag write ports
//   pc_tag_o, rs1_tag_wb_o    registered PC tag and WB load-address tag
//   exc_*                     tag exception handshake and status
module riscv_dift_tag_ex_unit #(
  parameter int TAG_WIDTH  = 4,
  parameter int MODE_WIDTH = 2,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [MODE_WIDTH-1:0]        mode_i,
  input  logic [TAG_WIDTH-1:0]         tag_a_i,
  input  logic [TAG_WIDTH-1:0]         tag_b_i,
  input  logic [TAG_WIDTH-1:0]         tag_c_i,
  input  logic                         check_s1_i,
  input  logic                         check_s2_i,
  input  logic                         check_d_i,
  input  logic                         register_set_i,
  input  logic                         rf_we_i,
  input  logic                         data_we_i,
  input  logic                         load_i,
  input  logic                         branch_taken_i,
  input  logic                         ex_valid_i,
  input  logic                         wb_ready_i,
  input  logic                         cfg_we_i,
  input  logic [2*(2**MODE_WIDTH)-1:0] cfg_policy_i,
  input  logic [TAG_WIDTH-1:0]         cfg_mask_i,
  input  logic                         cfg_clear_i,
  output logic [TAG_WIDTH-1:0]         rf_wdata_tag_o,
  output logic                         rf_we_tag_o,
  output logic [TAG_WIDTH-1:0]         data_wdata_tag_o,
  output logic                         data_we_tag_o,
  output logic [TAG_WIDTH-1:0]         pc_tag_o,
  output logic [TAG_WIDTH-1:0]         rs1_tag_wb_o,
  output logic                         exc_req_o,
  output logic [2:0]                   exc_cause_o,
  input  logic                         exc_ack_i,
  output logic                         exc_overrun_o,
  output logic [CNT_WIDTH-1:0]         exc_count_o
);

  localparam int NUM_MODES = 2**MODE_WIDTH;
  localparam int PW        = 2*NUM_MODES;

  typedef enum logic {IDLE, REQ} state_e;

  state_e                 state_q, state_d;
  logic [PW-1:0]          policy_q, policy_d;
  logic [TAG_WIDTH-1:0]   mask_q, mask_d;
  logic [TAG_WIDTH-1:0]   pc_tag_q, pc_tag_d;
  logic [TAG_WIDTH-1:0]   rs1_tag_q, rs1_tag_d;
  logic [2:0]             cause_q, cause_d;
  logic                   ovr_q, ovr_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

  logic [1:0]             op;
  logic                   op_en;
  logic [TAG_WIDTH-1:0]   res;
  logic [2:0]             viol;
  logic                   evt;

  // wb_ready_i does not gate the WB tag: it only moves with a valid EX load
  logic unused_wb_ready;
  assign unused_wb_ready = wb_ready_i;

  always_comb begin
    op    = policy_q[{mode_i, 1'b0} +: 2];
    op_en = (op != 2'b00);
    res   = '0;
    unique case (op)
      2'b00: res = '0;
      2'b01: res = tag_a_i | tag_b_i;
      2'b10: res = tag_a_i & tag_b_i;
      2'b11: res = tag_a_i;
    endcase
  end

  assign rf_wdata_tag_o   = register_set_i ? '1 : res;
  assign rf_we_tag_o      = register_set_i | (rf_we_i & op_en);
  assign data_wdata_tag_o = res;
  assign data_we_tag_o    = data_we_i & op_en;

  // loaded data carries its own tag, so the result check is skipped
  assign viol = {check_d_i & ~load_i & |(res & mask_q),
                 check_s2_i & |(tag_b_i & mask_q),
                 check_s1_i & |(tag_a_i & mask_q)};
  assign evt  = ex_valid_i & |viol;

  always_comb begin
    state_d   = state_q;
    policy_d  = policy_q;
    mask_d    = mask_q;
    pc_tag_d  = pc_tag_q;
    rs1_tag_d = rs1_tag_q;
    cause_d   = cause_q;
    ovr_d     = ovr_q;
    cnt_d     = cnt_q;

    if (cfg_we_i) begin
      policy_d = cfg_policy_i;
      mask_d   = cfg_mask_i;
    end

    if (ex_valid_i && branch_taken_i)
      pc_tag_d = (tag_c_i != '0) ? tag_c_i : res;

    if (ex_valid_i && load_i)
      rs1_tag_d = tag_a_i;

    unique case (state_q)
      IDLE: begin
        if (evt) begin
          state_d = REQ;
          cause_d = viol;
        end
      end
      REQ: begin
        if (evt)
          ovr_d = 1'b1;
        if (exc_ack_i)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (evt && cnt_q != '1)
      cnt_d = cnt_q + CNT_WIDTH'(1);

    if (cfg_clear_i) begin
      pc_tag_d = '0;
      cnt_d    = '0;
      ovr_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      policy_q  <= {NUM_MODES{2'b01}};
      mask_q    <= '1;
      pc_tag_q  <= '0;
      rs1_tag_q <= '0;
      cause_q   <= '0;
      ovr_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      policy_q  <= policy_d;
      mask_q    <= mask_d;
      pc_tag_q  <= pc_tag_d;
      rs1_tag_q <= rs1_tag_d;
      cause_q   <= cause_d;
      ovr_q     <= ovr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pc_tag_o      = pc_tag_q;
  assign rs1_tag_wb_o  = rs1_tag_q;
  assign exc_req_o     = (state_q == REQ);
  assign exc_cause_o   = cause_q;
  assign exc_overrun_o = ovr_q;
  assign exc_count_o   = cnt_q;

endmodule

// File: tb/tb_riscv_dift_tag_ex_unit.sv
// Scoreboard bench for riscv_dift_tag_ex_unit: random and directed
// stimulus checked against a behavioural tag-policy model.
module tb_riscv_dift_tag_ex_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] mode_i = '0;
  logic [3:0] tag_a_i = '0, tag_b_i = '0, tag_c_i = '0;
  logic       check_s1_i = 0, check_s2_i = 0, check_d_i = 0;
  logic       register_set_i = 0, rf_we_i = 0, data_we_i = 0;
  logic       load_i = 0, branch_taken_i = 0;
  logic       ex_valid_i = 0, wb_ready_i = 0;
  logic       cfg_we_i = 0, cfg_clear_i = 0, exc_ack_i = 0;
  logic [7:0] cfg_policy_i = '0;
  logic [3:0] cfg_mask_i = '0;
  logic [3:0] rf_wdata_tag_o, data_wdata_tag_o, pc_tag_o, rs1_tag_wb_o;
  logic       rf_we_tag_o, data_we_tag_o, exc_req_o, exc_overrun_o;
  logic [2:0] exc_cause_o;
  logic [7:0] exc_count_o;

  riscv_dift_tag_ex_unit dut (
    .clk(clk), .rst_n(rst_n), .mode_i(mode_i),
    .tag_a_i(tag_a_i), .tag_b_i(tag_b_i), .tag_c_i(tag_c_i),
    .check_s1_i(check_s1_i), .check_s2_i(check_s2_i),
    .check_d_i(check_d_i), .register_set_i(register_set_i),
    .rf_we_i(rf_we_i), .data_we_i(data_we_i), .load_i(load_i),
    .branch_taken_i(branch_taken_i), .ex_valid_i(ex_valid_i),
    .wb_ready_i(wb_ready_i), .cfg_we_i(cfg_we_i),
    .cfg_policy_i(cfg_policy_i), .cfg_mask_i(cfg_mask_i),
    .cfg_clear_i(cfg_clear_i), .rf_wdata_tag_o(rf_wdata_tag_o),
    .rf_we_tag_o(rf_we_tag_o), .data_wdata_tag_o(data_wdata_tag_o),
    .data_we_tag_o(data_we_tag_o), .pc_tag_o(pc_tag_o),
    .rs1_tag_wb_o(rs1_tag_wb_o), .exc_req_o(exc_req_o),
    .exc_cause_o(exc_cause_o), .exc_ack_i(exc_ack_i),
    .exc_overrun_o(exc_overrun_o), .exc_count_o(exc_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mode, a, b, c;
    bit cs1, cs2, cd, rs, rfwe, dwe, ld, br, val, wbr;
    bit cwe, cclr, ack;
    int cpol, cmask;
  } stim_t;

  typedef struct {
    int rfw, rfe, dw, de, pc, rs1, req, cause, ovr, cnt;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  // behavioural model state
  int m_pol[4];
  int m_mask, m_pc, m_rs1, m_cause, m_cnt;
  bit m_pend, m_ovr;

  task automatic chk(input string n, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_pol[i] = 1;
    m_mask = 15; m_pc = 0; m_rs1 = 0; m_cause = 0; m_cnt = 0;
    m_pend = 0; m_ovr = 0;
  endtask

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("rf_wdata_tag", int'(rf_wdata_tag_o), e.rfw);
      chk("rf_we_tag", int'(rf_we_tag_o), e.rfe);
      chk("data_wdata_tag", int'(data_wdata_tag_o), e.dw);
      chk("data_we_tag", int'(data_we_tag_o), e.de);
      chk("pc_tag", int'(pc_tag_o), e.pc);
      chk("rs1_tag_wb", int'(rs1_tag_wb_o), e.rs1);
      chk("exc_req", int'(exc_req_o), e.req);
      chk("exc_cause", int'(exc_cause_o), e.cause);
      chk("exc_overrun", int'(exc_overrun_o), e.ovr);
      chk("exc_count", int'(exc_count_o), e.cnt);
    end
  end

  task automatic step(input stim_t s);
    exp_t e;
    int   op, res, v;
    bit   ev;
    @(posedge clk); #2;
    mode_i = 2'(s.mode); tag_a_i = 4'(s.a);
    tag_b_i = 4'(s.b); tag_c_i = 4'(s.c);
    check_s1_i = s.cs1; check_s2_i = s.cs2; check_d_i = s.cd;
    register_set_i = s.rs; rf_we_i = s.rfwe; data_we_i = s.dwe;
    load_i = s.ld; branch_taken_i = s.br; ex_valid_i = s.val;
    wb_ready_i = s.wbr; cfg_we_i = s.cwe; cfg_clear_i = s.cclr;
    cfg_policy_i = 8'(s.cpol); cfg_mask_i = 4'(s.cmask);
    exc_ack_i = s.ack;
    // propagation: 0 clear, 1 or, 2 and, 3 pass a
    op = m_pol[s.mode];
    case (op)
      0: res = 0;
      1: res = s.a | s.b;
      2: res = s.a & s.b;
      default: res = s.a;
    endcase
    e.rfw = s.rs ? 15 : res;
    e.rfe = int'(s.rs || (s.rfwe && op != 0));
    e.dw  = res;
    e.de  = int'(s.dwe && op != 0);
    e.pc = m_pc; e.rs1 = m_rs1; e.req = int'(m_pend);
    e.cause = m_cause; e.ovr = int'(m_ovr); e.cnt = m_cnt;
    q.push_back(e);
    v = 0;
    if (s.cs1 && (s.a & m_mask) != 0) v += 1;
    if (s.cs2 && (s.b & m_mask) != 0) v += 2;
    if (s.cd && !s.ld && (res & m_mask) != 0) v += 4;
    ev = s.val && v != 0;
    if (m_pend) begin
      if (ev) m_ovr = 1;
      if (s.ack) m_pend = 0;
    end else if (ev) begin
      m_pend = 1; m_cause = v;
    end
    if (ev && m_cnt < 255) m_cnt++;
    if (s.val && s.br) m_pc = (s.c != 0) ? s.c : res;
    if (s.val && s.ld) m_rs1 = s.a;
    if (s.cclr) begin m_pc = 0; m_cnt = 0; m_ovr = 0; end
    if (s.cwe) begin
      for (int i = 0; i < 4; i++) m_pol[i] = (s.cpol >> (2*i)) & 3;
      m_mask = s.cmask;
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s.mode = $urandom_range(0, 3);
    s.a = $urandom_range(0, 15); s.b = $urandom_range(0, 15);
    s.c = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 15);
    s.cs1 = ($urandom_range(0, 3) == 0);
    s.cs2 = ($urandom_range(0, 3) == 0);
    s.cd  = ($urandom_range(0, 3) == 0);
    s.rs  = ($urandom_range(0, 7) == 0);
    s.rfwe = 1'($urandom_range(0, 1));
    s.dwe  = 1'($urandom_range(0, 1));
    s.ld   = ($urandom_range(0, 3) == 0);
    s.br   = ($urandom_range(0, 2) == 0);
    s.val  = ($urandom_range(0, 3) != 0);
    s.wbr  = 1'($urandom_range(0, 1));
    s.cwe  = ($urandom_range(0, 19) == 0);
    s.cclr = ($urandom_range(0, 24) == 0);
    s.ack  = ($urandom_range(0, 2) == 0);
    s.cpol = $urandom_range(0, 255);
    s.cmask = $urandom_range(1, 15);
    return s;
  endfunction

  initial begin
    stim_t s;
    int    w;
    model_reset();
    #3;
    chk("rst_pc_tag", int'(pc_tag_o), 0);
    chk("rst_rs1_tag", int'(rs1_tag_wb_o), 0);
    chk("rst_req", int'(exc_req_o), 0);
    chk("rst_cause", int'(exc_cause_o), 0);
    chk("rst_ovr", int'(exc_overrun_o), 0);
    chk("rst_cnt", int'(exc_count_o), 0);
    @(negedge clk); rst_n = 1'b1;

    // OR propagation, then mode 0 reprogrammed to CLEAR
    s = idle(); s.a = 1; s.b = 2; s.rfwe = 1; step(s);
    s.cwe = 1; s.cpol = 8'b01010100; s.cmask = 15; step(s);
    s = idle(); s.a = 1; s.b = 2; s.rfwe = 1; step(s);

    // mask 8, source-1 violation, request, ack
    s = idle(); s.cwe = 1; s.cpol = 8'h55; s.cmask = 8; step(s);
    s = idle(); s.cs1 = 1; s.a = 8; s.val = 1; step(s);
    step(idle()); step(idle());
    s = idle(); s.ack = 1; step(s);
    step(idle());

    // overrun while pending, then clear keeps request
    s = idle(); s.cs1 = 1; s.a = 8; s.val = 1; step(s);
    step(idle());
    s = idle(); s.cs2 = 1; s.b = 8; s.val = 1; step(s);
    step(idle());
    s = idle(); s.cclr = 1; step(s);
    step(idle());
    s = idle(); s.ack = 1; step(s);
    step(idle());

    // PC tag: result, jump target tag, not-taken hold
    s = idle(); s.val = 1; s.br = 1; s.a = 4; step(s);
    s = idle(); s.val = 1; s.br = 1; s.c = 2; s.a = 1; step(s);
    s = idle(); s.val = 1; s.a = 7; step(s);
    step(idle());

    // load suppresses result check, captures rs1 tag
    s = idle(); s.val = 1; s.ld = 1; s.cd = 1; s.a = 10; step(s);
    step(idle());
    s = idle(); s.wbr = 1; step(s);

    for (int i = 0; i < 2000; i++) step(rnd());

    // counter saturation with request held pending
    s = idle(); s.cwe = 1; s.cpol = 8'h55; s.cmask = 15; s.cclr = 1;
    step(s);
    for (int i = 0; i < 300; i++) begin
      s = idle(); s.cs1 = 1; s.a = 1; s.val = 1; step(s);
    end
    step(idle());

    // async reset in the middle of a request
    @(posedge clk); #2;
    chk("pre_rst_req", int'(exc_req_o), int'(m_pend));
    chk("pre_rst_cnt", int'(exc_count_o), m_cnt);
    #1 rst_n = 1'b0;
    #1;
    chk("async_pc_tag", int'(pc_tag_o), 0);
    chk("async_rs1_tag", int'(rs1_tag_wb_o), 0);
    chk("async_req", int'(exc_req_o), 0);
    chk("async_cause", int'(exc_cause_o), 0);
    chk("async_ovr", int'(exc_overrun_o), 0);
    chk("async_cnt", int'(exc_count_o), 0);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 50; i++) step(rnd());

    w = 0;
    while (q.size() > 0 && w < 10) begin
      @(posedge clk); w++;
    end
    if (q.size() > 0) chk("drain_timeout", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
